// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register for the 5-stage RV32I core.
//
// Captures the decoded instruction fields from ID and presents them to EX one
// cycle later. It also contains the load-use hazard detector, and it handles
// flush (bubble), EX hold (freeze) and bubble insertion. A saturating counter
// records how many bubbles have been inserted since reset.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_valid              ID slot holds a real instruction
//   id_pc, id_imm         instruction PC, sign-extended immediate (XLEN)
//   id_rs1/rs2_data       register-file read data (XLEN)
//   id_rs1/rs2/rd         register indices (REG_AW)
//   id_funct3/funct7      instr[14:12] / instr[31:25]
//   id_alu_op             00 LW/SW/AUIPC, 01 branch, 10 R/I, 11 JAL/LUI
//   id_alu_src .. id_jump single-bit control fields
//   ex_hold               downstream freeze request
//   flush                 branch/jump taken in EX, kill ID->EX transfer
//   ex_*                  registered copies of the id_* fields
//   stall_o               combinational: IF/ID and PC must hold this cycle
//   bubble_cnt            saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // All pipeline fields are packed together so a bubble is simply all-zero.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
  } fields_t;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'b00,
    ACT_BUBBLE = 2'b01,
    ACT_HOLD   = 2'b10
  } act_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fields_t          ex_q;
  fields_t          id_next;
  logic [CNT_W-1:0] cnt_q;
  logic             load_use;
  act_t             act;

  // Load-use hazard: the load in EX writes a register that ID reads. rs2 is
  // compared even for I-type; the occasional false stall is harmless.
  always_comb begin
    load_use = 1'b0;
    if (ex_q.valid && ex_q.mem_read && (ex_q.rd != {REG_AW{1'b0}}) && id_valid &&
        ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2))) begin
      load_use = 1'b1;
    end else begin
      load_use = 1'b0;
    end
  end

  assign stall_o = (ex_hold | load_use) & ~flush;

  // Gather the ID fields; an invalid slot has its side-effect bits cleared.
  always_comb begin
    id_next            = '0;
    id_next.valid      = id_valid;
    id_next.pc         = id_pc;
    id_next.rs1_data   = id_rs1_data;
    id_next.rs2_data   = id_rs2_data;
    id_next.imm        = id_imm;
    id_next.rs1        = id_rs1;
    id_next.rs2        = id_rs2;
    id_next.rd         = id_rd;
    id_next.funct3     = id_funct3;
    id_next.funct7     = id_funct7;
    id_next.alu_op     = id_alu_op;
    id_next.alu_src    = id_alu_src;
    id_next.mem_to_reg = id_mem_to_reg;
    if (id_valid) begin
      id_next.mem_read  = id_mem_read;
      id_next.mem_write = id_mem_write;
      id_next.reg_write = id_reg_write;
      id_next.branch    = id_branch;
      id_next.jump      = id_jump;
    end else begin
      id_next.mem_read  = 1'b0;
      id_next.mem_write = 1'b0;
      id_next.reg_write = 1'b0;
      id_next.branch    = 1'b0;
      id_next.jump      = 1'b0;
    end
  end

  // Edge action, priority flush > hold > load-use > load (reset handled in the flop).
  always_comb begin
    act = ACT_LOAD;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (ex_hold) begin
      act = ACT_HOLD;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_LOAD;
    end
  end

  // Pipeline register and saturating bubble counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      case (act)
        ACT_LOAD: begin
          ex_q <= id_next;
        end
        ACT_BUBBLE: begin
          ex_q <= '0;
          if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ACT_HOLD: begin
          ex_q <= ex_q;
        end
        default: begin
          ex_q <= '0;
        end
      endcase
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_funct7     = ex_q.funct7;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_branch     = ex_q.branch;
  assign ex_jump       = ex_q.jump;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg -- directed self-checking bench for id_ex_reg (CNT_W=2 so that
// counter saturation is reachable with a handful of flushes).
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]        id_funct3;
  logic [6:0]        id_funct7;
  logic [1:0]        id_alu_op;
  logic              id_alu_src, id_mem_read, id_mem_write, id_reg_write;
  logic              id_mem_to_reg, id_branch, id_jump;
  logic              ex_hold, flush;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic [1:0]        ex_alu_op;
  logic              ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic              ex_mem_to_reg, ex_branch, ex_jump;
  logic              stall_o;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .id_jump(id_jump), .ex_hold(ex_hold), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_funct3 = 3'd0; id_funct7 = 7'd0;
    id_alu_op = 2'b00; id_alu_src = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_reg_write = 1'b0; id_mem_to_reg = 1'b0; id_branch = 1'b0; id_jump = 1'b0;
  endtask

  // Simple valid instruction: rs1, rs2, rd, mem_read, alu_op.
  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic mr, input logic [1:0] op);
    clear_id();
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_mem_read = mr; id_reg_write = 1'b1; id_alu_op = op;
    id_pc = 32'h0000_1000 + {27'd0, rd};
  endtask

  initial begin
    reset = 1'b1; ex_hold = 1'b0; flush = 1'b0;
    // Every id_* nonzero during reset.
    id_valid = 1'b1; id_pc = 32'h0000_0100; id_rs1_data = 32'hAAAA_0001;
    id_rs2_data = 32'hBBBB_0002; id_imm = 32'hFFFF_FFF0; id_rs1 = 5'd1; id_rs2 = 5'd2;
    id_rd = 5'd3; id_funct3 = 3'b101; id_funct7 = 7'b0100000; id_alu_op = 2'b11;
    id_alu_src = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1; id_reg_write = 1'b1;
    id_mem_to_reg = 1'b1; id_branch = 1'b1; id_jump = 1'b1;
    step(); step();
    check_eq("rst_valid", {63'd0, ex_valid}, 64'd0);
    check_eq("rst_pc", {32'd0, ex_pc}, 64'd0);
    check_eq("rst_ctrl", {58'd0, ex_alu_op, ex_mem_read, ex_reg_write, ex_jump, ex_alu_src}, 64'd0);
    check_eq("rst_cnt", {62'd0, bubble_cnt}, 64'd0);
    check_eq("rst_stall", {63'd0, stall_o}, 64'd0);

    // Release reset: next edge mirrors id_*.
    reset = 1'b0;
    step();
    check_eq("post_rst_pc", {32'd0, ex_pc}, 64'h100);
    check_eq("post_rst_imm", {32'd0, ex_imm}, 64'hFFFF_FFF0);
    check_eq("post_rst_rs2d", {32'd0, ex_rs2_data}, 64'hBBBB_0002);
    check_eq("post_rst_f", {54'd0, ex_funct3, ex_funct7}, {54'd0, 3'b101, 7'b0100000});
    check_eq("post_rst_ctrl", {56'd0, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump}, 64'hFF);
    check_eq("post_rst_op", {62'd0, ex_alu_op}, 64'd3);

    // Pass-through: sub x5.
    set_instr(5'd1, 5'd2, 5'd5, 1'b0, 2'b10);
    id_funct3 = 3'b000; id_funct7 = 7'b0100000;
    #1 check_eq("pt_nostall", {63'd0, stall_o}, 64'd0);
    step();
    check_eq("pt_op", {62'd0, ex_alu_op}, 64'd2);
    check_eq("pt_f3", {61'd0, ex_funct3}, 64'd0);
    check_eq("pt_f7", {57'd0, ex_funct7}, 64'h20);
    check_eq("pt_rd", {59'd0, ex_rd}, 64'd5);
    check_eq("pt_rw", {62'd0, ex_reg_write, ex_valid}, 64'd3);

    // Load-use: lw x6, then add with rs2=6.
    set_instr(5'd1, 5'd0, 5'd6, 1'b1, 2'b00);
    step();
    check_eq("lw_in_ex", {58'd0, ex_mem_read, ex_rd}, {58'd0, 1'b1, 5'd6});
    set_instr(5'd7, 5'd6, 5'd8, 1'b0, 2'b10);
    #1 check_eq("lu_stall", {63'd0, stall_o}, 64'd1);
    step();
    check_eq("lu_bubble", {56'd0, ex_valid, ex_mem_read, ex_reg_write, ex_rd}, 64'd0);
    check_eq("lu_cnt", {62'd0, bubble_cnt}, 64'd1);
    check_eq("lu_stall_clr", {63'd0, stall_o}, 64'd0);
    step();
    check_eq("lu_add_rd", {59'd0, ex_rd}, 64'd8);
    check_eq("lu_add_rs2", {58'd0, ex_valid, ex_rs2}, {58'd0, 1'b1, 5'd6});

    // Load to x0: no hazard.
    set_instr(5'd0, 5'd0, 5'd0, 1'b1, 2'b00);
    step();
    set_instr(5'd0, 5'd0, 5'd9, 1'b0, 2'b10);
    #1 check_eq("x0_nostall", {63'd0, stall_o}, 64'd0);
    step();
    check_eq("x0_loaded", {58'd0, ex_valid, ex_rd}, {58'd0, 1'b1, 5'd9});
    check_eq("x0_cnt", {62'd0, bubble_cnt}, 64'd1);

    // Flush and hold together: flush wins.
    ex_hold = 1'b1; flush = 1'b1;
    #1 check_eq("fh_stall", {63'd0, stall_o}, 64'd0);
    step();
    check_eq("fh_bubble", {58'd0, ex_valid, ex_rd}, 64'd0);
    check_eq("fh_cnt", {62'd0, bubble_cnt}, 64'd2);
    ex_hold = 1'b0; flush = 1'b0;

    // Hold for 3 cycles while ID changes.
    set_instr(5'd1, 5'd2, 5'd10, 1'b0, 2'b10);
    step();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(5'd3, 5'd4, 5'd11 + i[4:0], 1'b0, 2'b01);
      #1 check_eq("hold_stall", {63'd0, stall_o}, 64'd1);
      step();
      check_eq("hold_rd", {59'd0, ex_rd}, 64'd10);
      check_eq("hold_pc", {32'd0, ex_pc}, 64'h100A);
      check_eq("hold_cnt", {62'd0, bubble_cnt}, 64'd2);
    end
    ex_hold = 1'b0;
    set_instr(5'd1, 5'd2, 5'd20, 1'b0, 2'b10);
    step();
    check_eq("hold_release", {59'd0, ex_rd}, 64'd20);

    // Invalid slot: side-effect bits cleared, data passes, not a bubble.
    clear_id();
    id_rd = 5'd17; id_reg_write = 1'b1; id_mem_write = 1'b1; id_mem_read = 1'b1;
    id_branch = 1'b1; id_jump = 1'b1; id_alu_src = 1'b1; id_mem_to_reg = 1'b1;
    id_imm = 32'h0000_0123;
    step();
    check_eq("inv_ctrl", {57'd0, ex_valid, ex_reg_write, ex_mem_write, ex_mem_read,
             ex_branch, ex_jump, ex_alu_src}, 64'd1);
    check_eq("inv_data", {27'd0, ex_mem_to_reg, ex_rd, ex_imm}, {27'd0, 1'b1, 5'd17, 32'h123});
    check_eq("inv_cnt", {62'd0, bubble_cnt}, 64'd2);

    // Reset asserted mid-hold clears everything.
    set_instr(5'd1, 5'd2, 5'd21, 1'b0, 2'b10);
    step();
    ex_hold = 1'b1; reset = 1'b1;
    step();
    check_eq("rst_hold_rd", {58'd0, ex_valid, ex_rd}, 64'd0);
    check_eq("rst_hold_cnt", {62'd0, bubble_cnt}, 64'd0);
    reset = 1'b0; ex_hold = 1'b0;
    #1 check_eq("rst_hold_stall", {63'd0, stall_o}, 64'd0);

    // Saturation with CNT_W=2: 1,2,3,3,3.
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("sat_cnt", {62'd0, bubble_cnt}, (i < 3) ? 64'(i + 1) : 64'd3);
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
